ibex_alu_iter: RTL and testbench
================================

// Module: ibex_alu_iter
// PURPOSE
// Parametrised, area-reduced multi-cycle ALU for the MAX10 Ibex build, sitting in the EX stage.
// Simple logic, add/sub and compare ops complete in 1 cycle.
// Shifts, rotates and bit counts run iteratively, SHIFT_STEP bits per cycle.
// Valid/ready handshakes on both sides replace the combinational result path.
// PARAMETERS
// WIDTH       32  datapath width; power of two, 8..64
// SHIFT_STEP  1   bits shifted/counted per cycle; power of two, 1..WIDTH
// RV32B       0   1 = enable ROL/ROR/MIN/MINU/MAX/MAXU/CLZ/CTZ/CPOP
// PORTS
// clk_i                in   1      clock, rising edge
// rst_ni               in   1      reset; asynchronous, active-low
// kill_i               in   1      flush in-flight op
// valid_i              in   1      operation request
// ready_o              out  1      block can accept request
// operator_i           in   alu_op_e  operation, sampled on accept
// operand_a_i          in   WIDTH  operand A, sampled on accept
// operand_b_i          in   WIDTH  operand B, sampled on accept
// valid_o              out  1      result available
// ready_i              in   1      consumer takes result
// result_o             out  WIDTH  registered result
// comparison_result_o  out  1      registered compare/branch outcome
// BEHAVIOUR
// - Reset: state IDLE; valid_o=0, result_o=0, comparison_result_o=0, ready_o=1.
// - Accept: valid_i&&ready_o at a rising edge. ready_o = (IDLE) | (DONE & ready_i), so back-to-back ops have no bubble.
// - FSM IDLE->BUSY on accepting an iterative op with steps>0.
// - FSM IDLE->DONE on accepting a simple op, a zero-amount shift, or an unsupported op.
// - FSM BUSY->DONE when the step counter reaches 0.
// - FSM DONE->IDLE on ready_i&!valid_i; DONE->BUSY/DONE on ready_i&valid_i (new accept); DONE holds while !ready_i.
// - valid_o=1 only in DONE; result_o and comparison_result_o are stable while valid_o&!ready_i.
// - Latency from accept to valid_o = 1 + steps.
// - steps for shift/rotate by n: ceil(n/SHIFT_STEP).
// - steps for CLZ/CTZ/CPOP: WIDTH/SHIFT_STEP, a constant independent of data.
// - Shift amount n = operand_b[$clog2(WIDTH)-1:0]; the upper bits are ignored.
// - Adder: (WIDTH+1)-bit {a,1}+{b^neg,neg} carry-in trick.
// - Compare ops: equality from a zero adder result; GE from MSB-mismatch logic, signed for GE/LT/SLT/MIN/MAX.
// - Compare result: EQ/NE/GE/GEU/LT/LTU/SLT/SLTU set comparison_result_o; result_o = {0,cmp}.
// - Simple ops: result_o for add/sub/AND/OR/XOR is the truncated WIDTH-bit value.
// - MIN/MAX: select A or B from the compare result in 1 cycle.
// - SRA fill = A[MSB].
// - SLL/ROL use bit-reversed A through the right shifter, then reverse the output.
// - ROR feeds the shifted-out bits back into the MSBs.
// - CTZ: the counter increments while the low bit is 0 and no 1 has been seen.
// - CLZ: same as CTZ on bit-reversed A.
// - Count results: zero input gives CLZ=CTZ=WIDTH; CPOP of all-ones = WIDTH. Counter width is $clog2(WIDTH)+1.
// - RV32B=0: B-extension ops are unsupported and take 1 cycle.
// - Unsupported op: result 0, cmp 0, 1 cycle.
// - kill_i (highest priority): next state IDLE, valid_o=0, result discarded; a same-cycle valid_i is not accepted.
// - Reset asserted mid-op aborts immediately to the reset values.
// - Operands and op are captured at accept; inputs changing during BUSY have no effect.
// STRUCTURE
// - ibex_pkg: extend alu_op_e with ALU_ROL, ALU_ROR, ALU_MIN, ALU_MINU, ALU_MAX, ALU_MAXU, ALU_CLZ, ALU_CTZ, ALU_CPOP.
// - ibex_pkg: add alu_iter_state_e {ALU_ITER_IDLE, ALU_ITER_BUSY, ALU_ITER_DONE}.
// - Sub-module ibex_alu_shift_step: combinational WIDTH-bit shift by SHIFT_STEP, with modes logical/arith/rotate.
// - ibex_alu_shift_step also outputs the shifted-out bits for CPOP/CTZ accumulation.
// - The top level holds the FSM, operand/count registers, the adder/compare path and the result mux.
// TESTING (WIDTH=32 unless noted)
// - SRA, SHIFT_STEP=1: A=0x80000000, B=4 -> valid_o 5 cycles after accept, result 0xF8000000; with SHIFT_STEP=4 -> 2 cycles.
// - SLTU then SLT back-to-back, ready_i=1: A=0xFFFFFFFF, B=1 -> results 0 then 1 on consecutive cycles; no bubble.
// - CTZ, SHIFT_STEP=1: A=0 -> 32 after 33 cycles; A=0x00000100 -> 8 after 33 cycles.
// - CPOP, SHIFT_STEP=8: A=0xF0F0F0F1 -> 17 after 5 cycles.
// - kill_i: assert kill_i in BUSY of SLL by 31 -> valid_o never rises; the next ADD 2+3 returns 5 at 1-cycle latency.
// - Backpressure: ADD with ready_i=0 for 10 cycles -> result_o stable, ready_o=0, new valid_i ignored.
// - RV32B=0: MAX issued -> result 0 in 1 cycle.

Source files
------------

// File: rtl/ibex_alu_iter_pkg.sv
// Shared types for the iterative Ibex ALU: operator encoding, FSM states and shifter modes.
package ibex_alu_iter_pkg;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
    ALU_SRA, ALU_SRL, ALU_SLL,
    ALU_LT, ALU_LTU, ALU_GE, ALU_GEU, ALU_EQ, ALU_NE, ALU_SLT, ALU_SLTU,
    ALU_ROL, ALU_ROR, ALU_MIN, ALU_MINU, ALU_MAX, ALU_MAXU,
    ALU_CLZ, ALU_CTZ, ALU_CPOP
  } alu_op_e;

  typedef enum logic [1:0] {
    ALU_ITER_IDLE,
    ALU_ITER_BUSY,
    ALU_ITER_DONE
  } alu_iter_state_e;

  typedef enum logic [1:0] {
    SHIFT_LOGIC,
    SHIFT_ARITH,
    SHIFT_ROT
  } shift_mode_e;

endpackage

// File: rtl/ibex_alu_iter_if.sv
// Request/response bundle between the EX stage (master) and the iterative ALU (slave).
interface ibex_alu_iter_if #(
  parameter int unsigned WIDTH = 32
);
  import ibex_alu_iter_pkg::*;

  logic             kill_i;
  logic             valid_i;
  logic             ready_o;
  alu_op_e          operator_i;
  logic [WIDTH-1:0] operand_a_i;
  logic [WIDTH-1:0] operand_b_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;
  logic             comparison_result_o;

  modport slave (
    input  kill_i, valid_i, operator_i, operand_a_i, operand_b_i, ready_i,
    output ready_o, valid_o, result_o, comparison_result_o
  );

  modport master (
    output kill_i, valid_i, operator_i, operand_a_i, operand_b_i, ready_i,
    input  ready_o, valid_o, result_o, comparison_result_o
  );
endinterface

// File: rtl/ibex_alu_iter_shift_step.sv
// One iteration of the right shifter: shifts by up to SHIFT_STEP bits and exposes the bits
// that fall off the bottom for bit counting.
module ibex_alu_iter_shift_step
  import ibex_alu_iter_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHIFT_STEP = 1,
  localparam int unsigned AmtW      = $clog2(SHIFT_STEP) + 1
) (
  input  logic [WIDTH-1:0]      i_data,
  input  logic [AmtW-1:0]       i_amt,
  input  shift_mode_e           i_mode,
  output logic [WIDTH-1:0]      o_data,
  output logic [SHIFT_STEP-1:0] o_out_bits
);

  logic [WIDTH-1:0] w_fill;

  always_comb begin
    unique case (i_mode)
      SHIFT_ARITH: w_fill = {WIDTH{i_data[WIDTH-1]}};
      SHIFT_ROT:   w_fill = i_data;
      default:     w_fill = '0;
    endcase
    // A shift by WIDTH yields zero, so amt==0 leaves the fill term empty.
    o_data = (i_data >> i_amt) | (w_fill << (WIDTH - 32'(i_amt)));
    for (int i = 0; i < int'(SHIFT_STEP); i++) begin
      o_out_bits[i] = i_data[i] & (i < int'(i_amt));
    end
  end

endmodule

// File: rtl/ibex_alu_iter.sv
// Area-reduced multi-cycle ALU: single-cycle add/logic/compare, iterative shifts and bit counts,
// valid/ready handshakes on request and result sides.
module ibex_alu_iter
  import ibex_alu_iter_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHIFT_STEP = 1,
  parameter bit          RV32B      = 1'b0
) (
  input logic            clk_i,
  input logic            rst_ni,
  ibex_alu_iter_if.slave alu_bus
);

  localparam int unsigned ShW  = $clog2(WIDTH);
  localparam int unsigned CntW = ShW + 1;
  localparam int unsigned AmtW = $clog2(SHIFT_STEP) + 1;

  alu_iter_state_e r_state, w_state_next;
  alu_op_e         r_op;
  logic [WIDTH-1:0] r_opa, r_result;
  logic [CntW-1:0]  r_steps, r_cnt;
  logic [AmtW-1:0]  r_amt;
  logic             r_seen, r_cmp;

  logic w_ready, w_valid, w_accept;
  logic [WIDTH-1:0] w_a, w_b, w_a_rev, w_sum, w_simple_res, w_shift_out, w_shift_rev, w_iter_res;
  logic [WIDTH:0]   w_adder;
  logic             w_unused_adder, w_neg, w_signed, w_eq, w_ge, w_simple_cmp, w_is_cmp;
  logic             w_is_shift, w_is_count, w_go_busy, w_seen_next;
  logic [ShW-1:0]   w_shamt;
  logic [31:0]      w_rem;
  logic [CntW-1:0]  w_steps, w_cnt_next;
  logic [AmtW-1:0]  w_first_amt;
  logic [SHIFT_STEP-1:0] w_out_bits;
  shift_mode_e      w_mode;

  assign w_a = alu_bus.operand_a_i;
  assign w_b = alu_bus.operand_b_i;

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ALU_ITER_IDLE;
    else         r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    if (alu_bus.kill_i) begin
      w_state_next = ALU_ITER_IDLE;
    end else begin
      unique case (r_state)
        ALU_ITER_IDLE: if (w_accept) w_state_next = w_go_busy ? ALU_ITER_BUSY : ALU_ITER_DONE;
        ALU_ITER_BUSY: if (r_steps == CntW'(1)) w_state_next = ALU_ITER_DONE;
        ALU_ITER_DONE: begin
          if (w_accept)              w_state_next = w_go_busy ? ALU_ITER_BUSY : ALU_ITER_DONE;
          else if (alu_bus.ready_i)  w_state_next = ALU_ITER_IDLE;
        end
        default: w_state_next = ALU_ITER_IDLE;
      endcase
    end
  end

  // FSM: outputs; DONE with ready_i lets a new op in on the same edge the result leaves
  always_comb begin
    w_valid  = (r_state == ALU_ITER_DONE);
    w_ready  = (r_state == ALU_ITER_IDLE) | (w_valid & alu_bus.ready_i);
    w_accept = alu_bus.valid_i & w_ready & ~alu_bus.kill_i;
  end

  assign alu_bus.ready_o             = w_ready;
  assign alu_bus.valid_o             = w_valid;
  assign alu_bus.result_o            = r_result;
  assign alu_bus.comparison_result_o = r_cmp;

  // Adder and comparator
  assign w_neg          = (alu_bus.operator_i != ALU_ADD);
  assign w_adder        = {w_a, 1'b1} + {w_b ^ {WIDTH{w_neg}}, w_neg};
  assign w_sum          = w_adder[WIDTH:1];
  assign w_unused_adder = w_adder[0];
  assign w_signed = alu_bus.operator_i inside {ALU_LT, ALU_GE, ALU_SLT, ALU_MIN, ALU_MAX};
  assign w_eq     = (w_sum == '0);
  assign w_ge     = (w_a[WIDTH-1] == w_b[WIDTH-1]) ? ~w_sum[WIDTH-1] :
                    (w_signed ? w_b[WIDTH-1] : w_a[WIDTH-1]);
  assign w_is_cmp = alu_bus.operator_i inside {ALU_EQ, ALU_NE, ALU_GE, ALU_GEU,
                                              ALU_LT, ALU_LTU, ALU_SLT, ALU_SLTU};

  always_comb begin
    w_simple_res = '0;
    w_simple_cmp = 1'b0;
    unique case (alu_bus.operator_i)
      ALU_ADD, ALU_SUB:                   w_simple_res = w_sum;
      ALU_XOR:                            w_simple_res = w_a ^ w_b;
      ALU_OR:                             w_simple_res = w_a | w_b;
      ALU_AND:                            w_simple_res = w_a & w_b;
      ALU_SRA, ALU_SRL, ALU_SLL:          w_simple_res = w_a;
      ALU_ROL, ALU_ROR:                   if (RV32B) w_simple_res = w_a;
      ALU_EQ:                             w_simple_cmp = w_eq;
      ALU_NE:                             w_simple_cmp = ~w_eq;
      ALU_GE, ALU_GEU:                    w_simple_cmp = w_ge;
      ALU_LT, ALU_LTU, ALU_SLT, ALU_SLTU: w_simple_cmp = ~w_ge;
      ALU_MIN, ALU_MINU:                  if (RV32B) w_simple_res = w_ge ? w_b : w_a;
      ALU_MAX, ALU_MAXU:                  if (RV32B) w_simple_res = w_ge ? w_a : w_b;
      default: ;
    endcase
    if (w_is_cmp) w_simple_res = WIDTH'(w_simple_cmp);
  end

  // Iteration setup; a non-multiple amount does its remainder on the first step
  always_comb begin
    w_shamt    = w_b[ShW-1:0];
    w_is_shift = (alu_bus.operator_i inside {ALU_SRA, ALU_SRL, ALU_SLL}) |
                 (RV32B && (alu_bus.operator_i inside {ALU_ROL, ALU_ROR}));
    w_is_count = RV32B && (alu_bus.operator_i inside {ALU_CLZ, ALU_CTZ, ALU_CPOP});
    w_go_busy  = w_is_count | (w_is_shift & (w_shamt != '0));
    w_rem      = 32'(w_shamt) % SHIFT_STEP;
    if (w_is_count) begin
      w_steps     = CntW'(WIDTH / SHIFT_STEP);
      w_first_amt = AmtW'(SHIFT_STEP);
    end else begin
      w_steps     = CntW'((32'(w_shamt) + SHIFT_STEP - 1) / SHIFT_STEP);
      w_first_amt = (w_rem == 0) ? AmtW'(SHIFT_STEP) : AmtW'(w_rem);
    end
  end

  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_a_rev[i]     = w_a[WIDTH-1-i];
      w_shift_rev[i] = w_shift_out[WIDTH-1-i];
    end
  end

  assign w_mode = (r_op == ALU_SRA) ? SHIFT_ARITH :
                  (r_op inside {ALU_ROL, ALU_ROR}) ? SHIFT_ROT : SHIFT_LOGIC;

  ibex_alu_iter_shift_step #(
    .WIDTH      (WIDTH),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shift_step (
    .i_data     (r_opa),
    .i_amt      (r_amt),
    .i_mode     (w_mode),
    .o_data     (w_shift_out),
    .o_out_bits (w_out_bits)
  );

  // CTZ stops counting at the first 1; CLZ reuses it on the reversed operand
  always_comb begin
    w_cnt_next  = r_cnt;
    w_seen_next = r_seen;
    for (int i = 0; i < int'(SHIFT_STEP); i++) begin
      if (r_op == ALU_CPOP)                        w_cnt_next = w_cnt_next + CntW'(w_out_bits[i]);
      else if (!w_seen_next && !w_out_bits[i])     w_cnt_next = w_cnt_next + CntW'(1);
      if (w_out_bits[i]) w_seen_next = 1'b1;
    end
  end

  always_comb begin
    if (r_op inside {ALU_CLZ, ALU_CTZ, ALU_CPOP}) w_iter_res = WIDTH'(w_cnt_next);
    else if (r_op inside {ALU_SLL, ALU_ROL})      w_iter_res = w_shift_rev;
    else                                          w_iter_res = w_shift_out;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op     <= ALU_ADD;
      r_opa    <= '0;
      r_steps  <= '0;
      r_amt    <= AmtW'(SHIFT_STEP);
      r_cnt    <= '0;
      r_seen   <= 1'b0;
      r_result <= '0;
      r_cmp    <= 1'b0;
    end else if (w_accept) begin
      r_op    <= alu_bus.operator_i;
      r_opa   <= (alu_bus.operator_i inside {ALU_SLL, ALU_ROL, ALU_CLZ}) ? w_a_rev : w_a;
      r_steps <= w_steps;
      r_amt   <= w_first_amt;
      r_cnt   <= '0;
      r_seen  <= 1'b0;
      r_cmp   <= w_go_busy ? 1'b0 : w_simple_cmp;
      if (!w_go_busy) r_result <= w_simple_res;
    end else if (r_state == ALU_ITER_BUSY) begin
      r_opa    <= w_shift_out;
      r_steps  <= r_steps - CntW'(1);
      r_amt    <= AmtW'(SHIFT_STEP);
      r_cnt    <= w_cnt_next;
      r_seen   <= w_seen_next;
      r_result <= w_iter_res;
    end
  end

endmodule

// File: tb/tb_ibex_alu_iter.sv
// Directed bench for ibex_alu_iter: four instances (step 1/4/8 with B ops, step 1 without).
module tb_ibex_alu_iter;
  import ibex_alu_iter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        kill = 1'b0;
  logic        rdy = 1'b1;
  alu_op_e     op = ALU_ADD;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        vld [4];
  logic        o_valid [4];
  logic        o_ready [4];
  logic        o_cmp [4];
  logic [31:0] o_res [4];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  // 0: step 1, 1: step 4, 2: step 8 (all with B ops); 3: step 1 without B ops
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned Step = (g == 1) ? 4 : (g == 2) ? 8 : 1;
    localparam bit          Rv   = (g != 3);
    ibex_alu_iter_if #(.WIDTH(32)) u_if ();
    assign u_if.kill_i      = kill;
    assign u_if.valid_i     = vld[g];
    assign u_if.operator_i  = op;
    assign u_if.operand_a_i = a;
    assign u_if.operand_b_i = b;
    assign u_if.ready_i     = rdy;
    assign o_valid[g] = u_if.valid_o;
    assign o_ready[g] = u_if.ready_o;
    assign o_res[g]   = u_if.result_o;
    assign o_cmp[g]   = u_if.comparison_result_o;
    ibex_alu_iter #(.WIDTH(32), .SHIFT_STEP(Step), .RV32B(Rv)) u_dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .alu_bus (u_if.slave)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op on instance d, wait for valid_o, check latency/result, then drain it.
  task automatic run(input int d, input alu_op_e o, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] er, input logic ec, input int el, input string tag);
    int lat;
    op = o; a = av; b = bv; vld[d] = 1'b1;
    @(posedge clk); #1;
    vld[d] = 1'b0;
    lat = 1;
    while (!o_valid[d] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " valid"}, 32'(o_valid[d]), 32'd1);
    chk({tag, " latency"}, lat, el);
    chk({tag, " result"}, o_res[d], er);
    chk({tag, " cmp"}, 32'(o_cmp[d]), 32'(ec));
    @(posedge clk); #1;
  endtask

  initial begin
    logic ok;
    for (int i = 0; i < 4; i++) vld[i] = 1'b0;

    #3;
    chk("reset valid_o", 32'(o_valid[0]), 32'd0);
    chk("reset ready_o", 32'(o_ready[0]), 32'd1);
    chk("reset result_o", o_res[0], 32'd0);
    chk("reset cmp", 32'(o_cmp[0]), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(0, ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 5, "sra step1");
    run(1, ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 2, "sra step4");
    run(0, ALU_SLL, 32'h0000_0001, 32'h21, 32'h0000_0002, 1'b0, 2, "sll upper amt ignored");
    run(0, ALU_ROR, 32'h0000_0001, 32'd1, 32'h8000_0000, 1'b0, 2, "ror");
    run(1, ALU_ROL, 32'h8000_0001, 32'd5, 32'h0000_0030, 1'b0, 3, "rol step4");
    run(0, ALU_SRL, 32'h0000_1234, 32'd0, 32'h0000_1234, 1'b0, 1, "srl zero amount");
    run(0, ALU_CTZ, 32'h0000_0000, 32'd0, 32'd32, 1'b0, 33, "ctz zero");
    run(0, ALU_CTZ, 32'h0000_0100, 32'd0, 32'd8, 1'b0, 33, "ctz 0x100");
    run(2, ALU_CPOP, 32'hF0F0_F0F1, 32'd0, 32'd17, 1'b0, 5, "cpop step8");
    run(2, ALU_CLZ, 32'h0001_0000, 32'd0, 32'd15, 1'b0, 5, "clz step8");
    run(0, ALU_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1, "sub");
    run(0, ALU_EQ, 32'h55, 32'h55, 32'd1, 1'b1, 1, "eq");
    run(0, ALU_GEU, 32'h8000_0000, 32'd1, 32'd1, 1'b1, 1, "geu");
    run(0, ALU_MAX, 32'd5, 32'd9, 32'd9, 1'b0, 1, "max");
    run(0, ALU_MIN, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1, "min signed");
    run(0, ALU_MINU, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, "minu");
    run(3, ALU_MAX, 32'd5, 32'd9, 32'd0, 1'b0, 1, "max without B ops");

    // Back-to-back compares with no bubble
    op = ALU_SLTU; a = 32'hFFFF_FFFF; b = 32'd1; vld[0] = 1'b1;
    @(posedge clk); #1;
    op = ALU_SLT;
    chk("b2b sltu valid", 32'(o_valid[0]), 32'd1);
    chk("b2b sltu result", o_res[0], 32'd0);
    chk("b2b sltu ready", 32'(o_ready[0]), 32'd1);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    chk("b2b slt valid", 32'(o_valid[0]), 32'd1);
    chk("b2b slt result", o_res[0], 32'd1);
    chk("b2b slt cmp", 32'(o_cmp[0]), 32'd1);
    @(posedge clk); #1;
    chk("b2b drained", 32'(o_valid[0]), 32'd0);

    // Kill a long shift; a request in the kill cycle must be dropped
    op = ALU_SLL; a = 32'd1; b = 32'd31; vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    kill = 1'b1; op = ALU_ADD; a = 32'd2; b = 32'd3; vld[0] = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0; vld[0] = 1'b0;
    ok = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (o_valid[0]) ok = 1'b0;
    end
    chk("kill valid_o never rises", 32'(ok), 32'd1);
    run(0, ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1, "add after kill");

    // Backpressure: result held, new request ignored
    rdy = 1'b0;
    op = ALU_ADD; a = 32'd7; b = 32'd8; vld[0] = 1'b1;
    @(posedge clk); #1;
    op = ALU_SUB; a = 32'd100; b = 32'd1;
    chk("bp valid", 32'(o_valid[0]), 32'd1);
    chk("bp result", o_res[0], 32'd15);
    chk("bp ready_o", 32'(o_ready[0]), 32'd0);
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!o_valid[0] || o_res[0] !== 32'd15 || o_ready[0]) ok = 1'b0;
    end
    chk("bp held 10 cycles", 32'(ok), 32'd1);
    vld[0] = 1'b0; rdy = 1'b1;
    @(posedge clk); #1;
    chk("bp released idle", 32'(o_valid[0]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
